// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// The adder slice width and the controller state encoding live here.
package nibble_serial_adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

endpackage

// File: rtl/nibble_serial_adder_full_adder.sv
// Shared 4-bit ripple adder slice that the serial controller reuses once per nibble.
module Full_Adder_4bit
   import nibble_serial_adder_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout
);

   logic [NIBBLE_W:0] total;

   assign total = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
   assign sum   = total[NIBBLE_W-1:0];
   assign cout  = total[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds or subtracts two WIDTH-bit operands one nibble per clock, LSB first,
// reusing a single 4-bit adder and carrying between cycles in a register.
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_width_check
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
   end

   state_e                          state_q, state_d;
   logic [NIBBLES-1:0][NIBBLE_W-1:0] op_a_q, op_a_d;
   logic [NIBBLES-1:0][NIBBLE_W-1:0] op_b_q, op_b_d;
   logic [NIBBLES-1:0][NIBBLE_W-1:0] acc_q, acc_d;
   logic                            carry_q, carry_d;
   logic [IDX_W-1:0]                idx_q, idx_d;
   logic [WIDTH-1:0]                result_q, result_d;
   logic                            cout_q, cout_d;
   logic                            ovf_q, ovf_d;

   logic [NIBBLE_W-1:0] nib_sum;
   logic                nib_cout;

   Full_Adder_4bit u_adder (
      .a    (op_a_q[idx_q]),
      .b    (op_b_q[idx_q]),
      .cin  (carry_q),
      .sum  (nib_sum),
      .cout (nib_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_a_q   <= '0;
         op_b_q   <= '0;
         acc_q    <= '0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         acc_q    <= acc_d;
         carry_q  <= carry_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      acc_d    = acc_q;
      carry_d  = carry_q;
      idx_d    = idx_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;

      unique case (state_q)
         IDLE: begin
            // Subtraction is a + ~b + 1, so the +1 rides in as the initial carry.
            if (start) begin
               op_a_d  = a;
               op_b_d  = sub ? ~b : b;
               carry_d = sub;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d[idx_q] = nib_sum;
            carry_d      = nib_cout;
            idx_d        = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
               state_d  = DONE;
               result_d = acc_d;
               cout_d   = nib_cout;
               ovf_d    = op_a_q[NIBBLES-1][NIBBLE_W-1] ^ op_b_q[NIBBLES-1][NIBBLE_W-1]
                          ^ nib_sum[NIBBLE_W-1] ^ nib_cout;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);
   assign result = result_q;
   assign cout   = cout_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder at WIDTH=16: directed table,
// multi-cycle corner sequences and randomized operations against an arithmetic model.
module tb_nibble_serial_adder;

   localparam int WIDTH = 16;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             ovf;

   int compared   = 0;
   int mismatched = 0;
   int doneCount  = 0;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             sub;
      logic [WIDTH-1:0] expResult;
      logic             expCout;
      logic             expOvf;
   } vec_t;

   vec_t vecs[5];

   nibble_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .sub    (sub),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (done) doneCount++;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference: signed/unsigned integer arithmetic, returns {cout, ovf, result}.
   function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                              input logic s);
      int sx, sy, full;
      logic [WIDTH-1:0] r;
      logic c, o;
      sx = int'($signed(x));
      sy = int'($signed(y));
      if (s) begin
         full = sx - sy;
         r    = x - y;
         c    = (x >= y);
      end else begin
         full = sx + sy;
         r    = x + y;
         c    = ((32'(x) + 32'(y)) > 32'h0000FFFF);
      end
      o = (full > 32767) || (full < -32768);
      return {c, o, r};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one request for a single cycle, then scramble the operand inputs.
   task automatic applyStimulus(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                input logic isub);
      @(negedge clk);
      a     = ia;
      b     = ib;
      sub   = isub;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = 16'($urandom);
      b     = 16'($urandom);
      sub   = 1'($urandom);
   endtask

   // Called one negedge after the start edge; returns negedges counted from the drive.
   task automatic waitDone(output int lat);
      lat = 1;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!done) lat = -1;
   endtask

   task automatic runOp(input string name, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic isub, input logic [WIDTH-1:0] expR, input logic expC,
                        input logic expO);
      int lat;
      applyStimulus(ia, ib, isub);
      checkOutput({name, "_busy"}, 32'(busy), 32'd1);
      waitDone(lat);
      checkOutput({name, "_latency"}, 32'(lat), 32'd5);
      checkOutput({name, "_result"}, 32'(result), 32'(expR));
      checkOutput({name, "_cout"}, 32'(cout), 32'(expC));
      checkOutput({name, "_ovf"}, 32'(ovf), 32'(expO));
      @(negedge clk);
      checkOutput({name, "_done_low"}, 32'(done), 32'd0);
      checkOutput({name, "_busy_low"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [WIDTH+1:0] exp;
      logic [WIDTH-1:0] ta, tb;
      logic             ts;
      int               lat, sinceDone, doneBefore;

      vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};

      rst_n = 1'b0;
      start = 1'b0;
      sub   = 1'b0;
      a     = '0;
      b     = '0;
      #12;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_result", 32'(result), 32'd0);
      checkOutput("reset_cout", 32'(cout), 32'd0);
      checkOutput("reset_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] directed vectors");
      foreach (vecs[i]) begin
         runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
               vecs[i].expResult, vecs[i].expCout, vecs[i].expOvf);
      end

      $display("[TB] start while busy");
      doneBefore = doneCount;
      applyStimulus(16'h1111, 16'h2222, 1'b0);
      a     = 16'hAAAA;
      b     = 16'h5555;
      sub   = 1'b0;
      start = 1'b1;
      waitDone(lat);
      checkOutput("busy_start_latency", 32'(lat), 32'd5);
      checkOutput("busy_start_result", 32'(result), 32'h3333);
      @(negedge clk);
      checkOutput("busy_start_done_once", 32'(doneCount - doneBefore), 32'd1);
      checkOutput("busy_start_not_in_done", 32'(busy), 32'd0);
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_start_idle_accept", 32'(busy), 32'd1);
      waitDone(lat);
      checkOutput("busy_start_second_latency", 32'(lat), 32'd5);
      checkOutput("busy_start_second_result", 32'(result), 32'hFFFF);
      @(negedge clk);

      $display("[TB] reset mid-operation");
      applyStimulus(16'h0F0F, 16'h0101, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_busy", 32'(busy), 32'd0);
      checkOutput("rst_mid_done", 32'(done), 32'd0);
      checkOutput("rst_mid_result", 32'(result), 32'd0);
      checkOutput("rst_mid_cout", 32'(cout), 32'd0);
      checkOutput("rst_mid_ovf", 32'(ovf), 32'd0);
      doneBefore = doneCount;
      repeat (4) @(negedge clk);
      checkOutput("rst_mid_no_done", 32'(doneCount - doneBefore), 32'd0);
      rst_n = 1'b1;
      exp = model(16'h0F0F, 16'h0101, 1'b0);
      runOp("rst_fresh", 16'h0F0F, 16'h0101, 1'b0, exp[WIDTH-1:0], exp[WIDTH+1], exp[WIDTH]);

      $display("[TB] randomized operations");
      for (int i = 0; i < 30; i++) begin
         ta  = 16'($urandom);
         tb  = 16'($urandom);
         ts  = 1'($urandom);
         if (i % 6 == 0) tb = ta;
         exp = model(ta, tb, ts);
         runOp($sformatf("rand%0d", i), ta, tb, ts, exp[WIDTH-1:0], exp[WIDTH+1], exp[WIDTH]);
      end

      $display("[TB] back-to-back with start held");
      @(negedge clk);
      start     = 1'b1;
      sinceDone = 0;
      for (int i = 0; i < 5; i++) begin
         ta  = 16'($urandom);
         tb  = 16'($urandom);
         ts  = 1'($urandom);
         a   = ta;
         b   = tb;
         sub = ts;
         exp = model(ta, tb, ts);
         lat = 0;
         do begin
            @(negedge clk);
            lat++;
            sinceDone++;
            if (!done) begin
               a   = 16'($urandom);
               b   = 16'($urandom);
               sub = 1'($urandom);
            end
         end while (!done && lat < 20);
         checkOutput($sformatf("b2b%0d_latency", i), 32'(lat), 32'd5);
         if (i > 0) checkOutput($sformatf("b2b%0d_interval", i), 32'(sinceDone), 32'd6);
         sinceDone = 0;
         checkOutput($sformatf("b2b%0d_result", i), 32'(result), 32'(exp[WIDTH-1:0]));
         checkOutput($sformatf("b2b%0d_cout", i), 32'(cout), 32'(exp[WIDTH+1]));
         checkOutput($sformatf("b2b%0d_ovf", i), 32'(ovf), 32'(exp[WIDTH]));
         @(negedge clk);
         sinceDone++;
         checkOutput($sformatf("b2b%0d_idle", i), 32'(busy), 32'd0);
      end
      start = 1'b0;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
